ray_result_fifo: RTL and testbench

Downstream stage of the nearest-hit comparator in the ray/triangle intersection pipeline. At the end of each ray's traversal it captures the comparator's held result (t, u, v, triID, anyhit) together with the ray identifier, and pulses the comparator's synchronous reset so the comparator can take the next ray. It buffers the results in a small FIFO and presents them to the result writer over a valid/ready handshake, forcing miss records to a canonical form.

---
 rtl/ray_result_pkg.sv | 48 ++++
 rtl/ray_result_mem.sv | 29 ++
 rtl/ray_result_fifo.sv | 133 +++++++++++++
 tb/tb_ray_result_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_result_pkg.sv
// Shared types for the nearest-hit result path: field widths, the miss
// sentinel, the packed result record and the FIFO occupancy states.
package ray_result_pkg;

   localparam int T_W   = 32;
   localparam int UV_W  = 16;
   localparam int TRI_W = 16;
   localparam int RAY_W = 16;

   localparam logic [T_W-1:0] MISS_T_DEFAULT = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [RAY_W-1:0] ray_id;
      logic             hit;
      logic [T_W-1:0]   t;
      logic [UV_W-1:0]  u;
      logic [UV_W-1:0]  v;
      logic [TRI_W-1:0] tri_id;
   } ray_result_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } fifo_state_e;

   // Misses collapse to one canonical record so the writer never sees stale
   // comparator contents.
   function automatic ray_result_t canon_result(
      input logic [RAY_W-1:0] ray_id,
      input logic             hit,
      input logic [T_W-1:0]   t,
      input logic [UV_W-1:0]  u,
      input logic [UV_W-1:0]  v,
      input logic [TRI_W-1:0] tri_id,
      input logic [T_W-1:0]   miss_t
   );
      ray_result_t r;
      r.ray_id = ray_id;
      r.hit    = hit;
      r.t      = hit ? t      : miss_t;
      r.u      = hit ? u      : '0;
      r.v      = hit ? v      : '0;
      r.tri_id = hit ? tri_id : '0;
      return r;
   endfunction

endpackage

// File: rtl/ray_result_mem.sv
// Result storage for ray_result_fifo: one synchronous write port and one
// asynchronous read port over DEPTH packed result records.
module ray_result_mem
   import ray_result_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [PTR_W-1:0] i_wr_addr,
   input  ray_result_t      i_wr_data,
   input  logic [PTR_W-1:0] i_rd_addr,
   output ray_result_t      o_rd_data
);

   ray_result_t r_mem [DEPTH];

   // NOTE: the array has no reset; an entry is only read after it has been
   // written, so clearing it would add reset fan-out for no functional gain.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ray_result_fifo.sv
// Captures one comparator result per finished ray, re-arms the comparator and
// queues the results for the writer with a registered first-word-fall-through head.
module ray_result_fifo
   import ray_result_pkg::*;
#(
   parameter int unsigned    DEPTH  = 4,
   parameter logic [T_W-1:0] MISS_T = MISS_T_DEFAULT
) (
   input  logic             clk,
   input  logic             globalreset,
   input  logic [T_W-1:0]   t,
   input  logic [UV_W-1:0]  u,
   input  logic [UV_W-1:0]  v,
   input  logic [TRI_W-1:0] triID,
   input  logic             anyhit,
   input  logic [RAY_W-1:0] rayID,
   input  logic             raydone,
   input  logic             flush,
   output logic             nearreset,
   output logic             full,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RAY_W-1:0] out_rayID,
   output logic             out_hit,
   output logic [T_W-1:0]   out_t,
   output logic [UV_W-1:0]  out_u,
   output logic [UV_W-1:0]  out_v,
   output logic [TRI_W-1:0] out_triID
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [PTR_W-1:0] w_wr_ptr_next, w_rd_ptr_next;
   logic [CNT_W-1:0] r_count, w_count_next;
   logic             r_overflow, r_nearreset;
   ray_result_t      r_head;
   ray_result_t      w_entry, w_mem_rd, w_head_next;
   fifo_state_e      w_state;
   logic             w_push, w_pop, w_drop;

   always_comb begin
      w_state = ST_PARTIAL;
      if (r_count == '0) begin
         w_state = ST_EMPTY;
      end else if (r_count == FULL_CNT) begin
         w_state = ST_FULL;
      end
   end

   assign full      = (w_state == ST_FULL);
   assign out_valid = (w_state != ST_EMPTY);
   assign overflow  = r_overflow;
   assign nearreset = r_nearreset;

   // flush wins over both handshakes; a full FIFO still accepts when it pops.
   assign w_pop  = out_valid & out_ready & ~flush;
   assign w_push = raydone & ~flush & (~full | w_pop);
   assign w_drop = raydone & ~flush & full & ~w_pop;

   assign w_entry = canon_result(rayID, anyhit, t, u, v, triID, MISS_T);

   always_comb begin
      w_count_next  = r_count;
      w_wr_ptr_next = r_wr_ptr;
      w_rd_ptr_next = r_rd_ptr;
      if (flush) begin
         w_count_next  = '0;
         w_wr_ptr_next = '0;
         w_rd_ptr_next = '0;
      end else begin
         if (w_push) w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
         if (w_pop)  w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
         end
      end
   end

   ray_result_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_entry),
      .i_rd_addr (w_rd_ptr_next),
      .o_rd_data (w_mem_rd)
   );

   // The next head may be the entry being written this very cycle.
   assign w_head_next = (w_push && (r_wr_ptr == w_rd_ptr_next)) ? w_entry : w_mem_rd;

   // NOTE: all state below uses non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational logic above.
   always_ff @(posedge clk or posedge globalreset) begin
      if (globalreset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_nearreset <= 1'b0;
         r_head      <= '0;
      end else begin
         r_wr_ptr    <= w_wr_ptr_next;
         r_rd_ptr    <= w_rd_ptr_next;
         r_count     <= w_count_next;
         r_nearreset <= raydone;
         if (flush) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_count_next != '0) begin
            r_head <= w_head_next;
         end
      end
   end

   assign out_rayID = r_head.ray_id;
   assign out_hit   = r_head.hit;
   assign out_t     = r_head.t;
   assign out_u     = r_head.u;
   assign out_v     = r_head.v;
   assign out_triID = r_head.tri_id;

endmodule

// File: tb/tb_ray_result_fifo.sv
// Scoreboard bench for ray_result_fifo: expected records are queued when a
// raydone is accepted and compared against the head while it is presented.
module tb_ray_result_fifo;
   import ray_result_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        globalreset;
   logic [31:0] t;
   logic [15:0] u, v, triID, rayID;
   logic        anyhit, raydone, flush, out_ready;
   logic        nearreset, full, overflow, out_valid, out_hit;
   logic [15:0] out_rayID, out_u, out_v, out_triID;
   logic [31:0] out_t;

   int checks = 0;
   int failures = 0;

   ray_result_t q[$];
   bit          m_ovf;
   bit          m_near;

   ray_result_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .globalreset(globalreset), .t(t), .u(u), .v(v), .triID(triID),
      .anyhit(anyhit), .rayID(rayID), .raydone(raydone), .flush(flush),
      .nearreset(nearreset), .full(full), .overflow(overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_rayID(out_rayID),
      .out_hit(out_hit), .out_t(out_t), .out_u(out_u), .out_v(out_v),
      .out_triID(out_triID)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic ray_result_t exp_rec(input logic [15:0] id, input logic hit,
      input logic [31:0] tt, input logic [15:0] uu, input logic [15:0] vv,
      input logic [15:0] tri_id);
      ray_result_t r;
      r.ray_id = id;
      r.hit    = hit;
      if (hit) begin
         r.t = tt; r.u = uu; r.v = vv; r.tri_id = tri_id;
      end else begin
         r.t = 32'hFFFF_FFFF; r.u = 16'h0; r.v = 16'h0; r.tri_id = 16'h0;
      end
      return r;
   endfunction

   // Called just after a falling edge: checks the state left by the last
   // rising edge, drives the next inputs, updates the model, steps one clock.
   task automatic cycle(input logic rd, input logic [15:0] id, input logic hit,
      input logic [31:0] tt, input logic [15:0] uu, input logic [15:0] vv,
      input logic [15:0] tri_id, input logic rdy, input logic fl);
      ray_result_t obs;
      bit pop, push, drop;
      checks++;
      if (out_valid !== (q.size() != 0)) begin
         failures++; $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
      end
      checks++;
      if (full !== (q.size() == DEPTH)) begin
         failures++; $display("FAIL full: got %b expected %b", full, q.size() == DEPTH);
      end
      checks++;
      if (overflow !== m_ovf) begin
         failures++; $display("FAIL overflow: got %b expected %b", overflow, m_ovf);
      end
      checks++;
      if (nearreset !== m_near) begin
         failures++; $display("FAIL nearreset: got %b expected %b", nearreset, m_near);
      end
      if (q.size() != 0) begin
         obs.ray_id = out_rayID; obs.hit = out_hit; obs.t = out_t;
         obs.u = out_u; obs.v = out_v; obs.tri_id = out_triID;
         checks++;
         if (obs !== q[0]) begin
            failures++; $display("FAIL head_data: got %h expected %h", obs, q[0]);
         end
      end
      raydone = rd; rayID = id; anyhit = hit; t = tt; u = uu; v = vv; triID = tri_id;
      out_ready = rdy; flush = fl;
      pop  = rdy && (q.size() != 0) && !fl;
      push = rd && !fl && ((q.size() < DEPTH) || pop);
      drop = rd && !fl && (q.size() == DEPTH) && !pop;
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(exp_rec(id, hit, tt, uu, vv, tri_id));
         if (drop) m_ovf = 1'b1;
      end
      m_near = rd;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0, 32'h0, 16'h0, 16'h0, 16'h0, rdy, 1'b0);
   endtask

   task automatic test_reset();
      globalreset = 1'b1;
      raydone = 0; rayID = 0; anyhit = 0; t = 0; u = 0; v = 0; triID = 0;
      flush = 0; out_ready = 0;
      q.delete(); m_ovf = 0; m_near = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, full, overflow, nearreset, out_rayID, out_hit, out_t, out_u, out_v, out_triID} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got v=%b f=%b o=%b n=%b id=%h t=%h expected all zero",
                  out_valid, full, overflow, nearreset, out_rayID, out_t);
      end
      globalreset = 1'b0;
      idle(2, 1'b0);
   endtask

   task automatic test_single_hit();
      cycle(1'b1, 16'd5, 1'b1, 32'h100, 16'h10, 16'h20, 16'd7, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_rayID !== 16'd5 || out_t !== 32'h100 || out_triID !== 16'd7) begin
         failures++; $display("FAIL single_hit_latency: got v=%b id=%0d t=%h tri=%0d expected v=1 id=5 t=100 tri=7",
                              out_valid, out_rayID, out_t, out_triID);
      end
      checks++;
      if (nearreset !== 1'b1) begin
         failures++; $display("FAIL single_hit_nearreset: got %b expected 1", nearreset);
      end
      idle(1, 1'b0);
      checks++;
      if (nearreset !== 1'b0 || out_valid !== 1'b1 || out_rayID !== 16'd5) begin
         failures++; $display("FAIL single_hit_hold: got n=%b v=%b id=%0d expected n=0 v=1 id=5",
                              nearreset, out_valid, out_rayID);
      end
      idle(1, 1'b1);
      idle(1, 1'b0);
   endtask

   task automatic test_miss();
      cycle(1'b1, 16'd6, 1'b0, 32'h1234, 16'h55, 16'h66, 16'd9, 1'b0, 1'b0);
      checks++;
      if (out_hit !== 1'b0 || out_t !== 32'hFFFF_FFFF || out_u !== 16'h0 || out_v !== 16'h0 || out_triID !== 16'h0) begin
         failures++; $display("FAIL miss_canon: got hit=%b t=%h u=%h v=%h tri=%h expected hit=0 t=ffffffff u=0 v=0 tri=0",
                              out_hit, out_t, out_u, out_v, out_triID);
      end
      idle(1, 1'b1);
      idle(1, 1'b0);
   endtask

   task automatic test_fill_drop();
      int pulses = 0;
      logic [15:0] drained[$];
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 16'(i), 1'b1, 32'(i * 16), 16'(i), 16'(i + 1), 16'(i + 2), 1'b0, 1'b0);
         if (nearreset === 1'b1) pulses++;
      end
      checks++;
      if (full !== 1'b1 || overflow !== 1'b0) begin
         failures++; $display("FAIL fill_full: got full=%b ovf=%b expected full=1 ovf=0", full, overflow);
      end
      cycle(1'b1, 16'd5, 1'b1, 32'h50, 16'h5, 16'h6, 16'h7, 1'b0, 1'b0);
      if (nearreset === 1'b1) pulses++;
      checks++;
      if (overflow !== 1'b1 || full !== 1'b1) begin
         failures++; $display("FAIL drop_overflow: got full=%b ovf=%b expected full=1 ovf=1", full, overflow);
      end
      for (int i = 0; i < 5; i++) begin
         if (out_valid === 1'b1) drained.push_back(out_rayID);
         idle(1, 1'b1);
         if (nearreset === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 5) begin
         failures++; $display("FAIL fill_nearreset_pulses: got %0d expected 5", pulses);
      end
      checks++;
      if (drained.size() != 4) begin
         failures++; $display("FAIL fill_drain_count: got %0d expected 4", drained.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (drained[i] !== 16'(i + 1)) begin
               failures++; $display("FAIL fill_drain_order[%0d]: got %0d expected %0d", i, drained[i], i + 1);
            end
         end
      end
   endtask

   task automatic test_flush();
      cycle(1'b1, 16'd20, 1'b1, 32'h200, 16'h1, 16'h2, 16'h3, 1'b0, 1'b0);
      cycle(1'b1, 16'd21, 1'b0, 32'h201, 16'h1, 16'h2, 16'h3, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b1) begin
         failures++; $display("FAIL flush_pre_overflow: got %b expected 1", overflow);
      end
      cycle(1'b1, 16'd22, 1'b1, 32'h202, 16'h1, 16'h2, 16'h3, 1'b1, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || nearreset !== 1'b1) begin
         failures++; $display("FAIL flush_clear: got v=%b f=%b o=%b n=%b expected v=0 f=0 o=0 n=1",
                              out_valid, full, overflow, nearreset);
      end
      idle(2, 1'b0);
   endtask

   task automatic test_full_pop();
      logic [15:0] drained[$];
      logic [15:0] exp_ids[4] = '{16'd2, 16'd3, 16'd4, 16'd9};
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 16'(i), 1'b1, 32'(i * 256), 16'(i), 16'(i), 16'(i), 1'b0, 1'b0);
      end
      cycle(1'b1, 16'd9, 1'b0, 32'h999, 16'h9, 16'h9, 16'h9, 1'b1, 1'b0);
      checks++;
      if (full !== 1'b1 || overflow !== 1'b0 || out_rayID !== 16'd2) begin
         failures++; $display("FAIL full_pop: got full=%b ovf=%b head=%0d expected full=1 ovf=0 head=2",
                              full, overflow, out_rayID);
      end
      for (int i = 0; i < 5; i++) begin
         if (out_valid === 1'b1) drained.push_back(out_rayID);
         idle(1, 1'b1);
      end
      checks++;
      if (drained.size() != 4) begin
         failures++; $display("FAIL full_pop_drain_count: got %0d expected 4", drained.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (drained[i] !== exp_ids[i]) begin
               failures++; $display("FAIL full_pop_order[%0d]: got %0d expected %0d", i, drained[i], exp_ids[i]);
            end
         end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 16'(100 + i), 1'(i % 3 != 0), 32'(1000 + i), 16'(i), 16'(2 * i), 16'(3 * i), 1'b1, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_rayID !== 16'(100 + i)) begin
            failures++; $display("FAIL wrap_stream[%0d]: got v=%b id=%0d expected v=1 id=%0d",
                                 i, out_valid, out_rayID, 100 + i);
         end
      end
      idle(1, 1'b1);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL wrap_drained: got v=%b expected 0", out_valid);
      end
      idle(1, 1'b0);
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 5; i++) begin
         cycle(1'b1, 16'(40 + i), 1'b1, 32'(i), 16'(i), 16'(i), 16'(i), 1'b0, 1'b0);
      end
      checks++;
      if (overflow !== 1'b1 || nearreset !== 1'b1 || out_valid !== 1'b1) begin
         failures++; $display("FAIL async_pre: got o=%b n=%b v=%b expected 1 1 1", overflow, nearreset, out_valid);
      end
      #2 globalreset = 1'b1;
      #1;
      checks++;
      if ({out_valid, full, overflow, nearreset, out_rayID, out_hit, out_t, out_u, out_v, out_triID} !== '0) begin
         failures++;
         $display("FAIL async_reset_clear: got v=%b f=%b o=%b n=%b id=%h t=%h expected all zero",
                  out_valid, full, overflow, nearreset, out_rayID, out_t);
      end
      q.delete(); m_ovf = 0; m_near = 0;
      @(negedge clk);
      globalreset = 1'b0;
      raydone = 1'b0; out_ready = 1'b0; flush = 1'b0;
      idle(2, 1'b0);
      cycle(1'b1, 16'd77, 1'b1, 32'h77, 16'h7, 16'h7, 16'h7, 1'b0, 1'b0);
      idle(1, 1'b1);
      idle(1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_hit();
      test_miss();
      test_fill_drop();
      test_flush();
      test_full_pop();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
